// File: rtl/sinc3_adc_seq_ctrl.sv
// Sequencer for NUM_CH sinc3 filters: shared reset/rate, settling discard, round-robin output.
// Define SINC3_SEQ_TIMESTAMP_EN to add a free-running timestamp presented on out_ts.
module sinc3_adc_seq_ctrl #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SETTLE_CNT = 3,
  parameter int unsigned RST_CYCLES = 4
`ifdef SINC3_SEQ_TIMESTAMP_EN
  ,
  parameter int unsigned TS_W       = 32
`endif
) (
  input  logic                      mclk1,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [15:0]               cfg_dec_rate,
  input  logic [NUM_CH-1:0]         cfg_ch_mask,
  output logic                      filt_rst,
  output logic [15:0]               dec_rate,
  input  logic [16*NUM_CH-1:0]      ch_data,
  input  logic [NUM_CH-1:0]         ch_data_en,
  output logic [15:0]               out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      cfg_err,
  output logic [NUM_CH-1:0]         overrun
`ifdef SINC3_SEQ_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]           out_ts
`endif
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned SW   = (SETTLE_CNT > 0) ? $clog2(SETTLE_CNT + 1) : 1;
  localparam int unsigned RW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StRst, StSettle, StRun, StDrain} state_e;

  state_e            state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] pend_q;
  logic [RW-1:0]     rst_cnt_q;
  logic [SW-1:0]     settle_cnt_q [NUM_CH];
  logic [15:0]       hold_q [NUM_CH];
  logic [CH_W-1:0]   last_q;

  logic [NUM_CH-1:0] settled;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] clr;
  logic              capture_en;
  logic              all_settled;
  logic              load;
  logic              found;
  logic              rate_ok;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   cand;

  assign busy = (state_q != StIdle);

  always_comb begin
    capture_en = (state_q == StSettle) || (state_q == StRun);
    for (int i = 0; i < NUM_CH; i++) begin
      settled[i] = (settle_cnt_q[i] == SW'(SETTLE_CNT));
      cap[i]     = capture_en && mask_q[i] && ch_data_en[i] && settled[i];
    end
    all_settled = &(settled | ~mask_q);
    load        = (!out_valid || out_ready) && (pend_q != '0);
    // Round-robin search starting one past the last granted channel
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_q) + k) % NUM_CH);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    clr = '0;
    if (load) clr[grant] = 1'b1;
    // Legal rates are the powers of two 32..4096
    rate_ok = $onehot(cfg_dec_rate[12:5]) && (cfg_dec_rate[15:13] == 3'b0) &&
              (cfg_dec_rate[4:0] == 5'b0);
  end

  always_ff @(posedge mclk1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      filt_rst  <= 1'b1;
      dec_rate  <= 16'd256;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      overrun   <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      rst_cnt_q <= '0;
      last_q    <= CH_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        settle_cnt_q[i] <= '0;
        hold_q[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) hold_q[i] <= ch_data[16*i +: 16];
        if (capture_en && mask_q[i] && ch_data_en[i] && !settled[i]) begin
          settle_cnt_q[i] <= settle_cnt_q[i] + 1'b1;
        end
      end
      // A capture on the channel being granted refills pend without counting as overrun
      pend_q  <= (pend_q & ~clr) | cap;
      overrun <= overrun | (cap & pend_q & ~clr);

      if (load) begin
        out_data  <= hold_q[grant];
        out_ch    <= grant;
        out_valid <= 1'b1;
        last_q    <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          filt_rst <= 1'b1;
          if (start) begin
            if (cfg_ch_mask == '0) begin
              cfg_err <= 1'b1;
            end else begin
              mask_q    <= cfg_ch_mask;
              dec_rate  <= rate_ok ? cfg_dec_rate : 16'd256;
              cfg_err   <= !rate_ok;
              overrun   <= '0;
              rst_cnt_q <= '0;
              for (int i = 0; i < NUM_CH; i++) settle_cnt_q[i] <= '0;
              state_q   <= StRst;
            end
          end
        end
        StRst: begin
          if (stop) begin
            state_q <= StDrain;
          end else if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
            filt_rst <= 1'b0;
            state_q  <= StSettle;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        StSettle: begin
          if (stop) state_q <= StDrain;
          else if (all_settled) state_q <= StRun;
        end
        StRun: begin
          if (stop) state_q <= StDrain;
        end
        StDrain: begin
          if ((pend_q == '0) && !out_valid) begin
            filt_rst <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SINC3_SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] hold_ts_q [NUM_CH];

  always_ff @(posedge mclk1 or negedge reset_n) begin
    if (!reset_n) begin
      ts_q   <= '0;
      out_ts <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_ts_q[i] <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) hold_ts_q[i] <= ts_q;
      end
      if (load) out_ts <= hold_ts_q[grant];
    end
  end
`endif

endmodule

// File: tb/tb_sinc3_adc_seq_ctrl.sv
// Directed bench for sinc3_adc_seq_ctrl: sequencing, settling, arbitration, overrun, drain, reset.
module tb_sinc3_adc_seq_ctrl;

  logic        mclk1;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [15:0] cfg_dec_rate;
  logic [3:0]  cfg_ch_mask;
  logic        filt_rst;
  logic [15:0] dec_rate;
  logic [63:0] ch_data;
  logic [3:0]  ch_data_en;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        cfg_err;
  logic [3:0]  overrun;
`ifdef SINC3_SEQ_TIMESTAMP_EN
  logic [31:0] out_ts;
`endif

  int checks = 0;
  int failures = 0;

  sinc3_adc_seq_ctrl dut (
    .mclk1        (mclk1),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .cfg_dec_rate (cfg_dec_rate),
    .cfg_ch_mask  (cfg_ch_mask),
    .filt_rst     (filt_rst),
    .dec_rate     (dec_rate),
    .ch_data      (ch_data),
    .ch_data_en   (ch_data_en),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .cfg_err      (cfg_err),
`ifdef SINC3_SEQ_TIMESTAMP_EN
    .out_ts       (out_ts),
`endif
    .overrun      (overrun)
  );

  initial mclk1 = 1'b0;
  always #5 mclk1 = ~mclk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge mclk1);
    #1;
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    cfg_dec_rate = 16'd0;
    cfg_ch_mask  = 4'h0;
    ch_data      = '0;
    ch_data_en   = 4'h0;
    out_ready    = 1'b1;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic do_start(input logic [15:0] rate, input logic [3:0] mask);
    cfg_dec_rate = rate;
    cfg_ch_mask  = mask;
    start        = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] en, input logic [15:0] base);
    for (int i = 0; i < 4; i++) ch_data[16*i +: 16] = base + 16'(i);
    ch_data_en = en;
    cyc();
    ch_data_en = 4'h0;
  endtask

  task automatic go_run(input logic [3:0] mask);
    do_start(16'd256, mask);
    repeat (4) cyc();
    repeat (3) strobe(4'hF, 16'h0100);
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (filt_rst !== 1'b1) begin failures++; $display("FAIL reset_filt_rst: got %0h expected 1", filt_rst); end
    checks++; if (dec_rate !== 16'd256) begin failures++; $display("FAIL reset_dec_rate: got %0d expected 256", dec_rate); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
    checks++; if (out_data !== 16'h0 || out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_data_ch: got %0h/%0h expected 0/0", out_data, out_ch); end
    checks++; if (busy !== 1'b0 || cfg_err !== 1'b0 || overrun !== 4'h0) begin failures++; $display("FAIL reset_flags: got busy=%0h cfg_err=%0h overrun=%0h expected 0/0/0", busy, cfg_err, overrun); end
  endtask

  task automatic test_settle_mask();
    apply_reset();
    do_start(16'd256, 4'b0101);
    checks++; if (filt_rst !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL start_rst: got filt_rst=%0h busy=%0h expected 1/1", filt_rst, busy); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (filt_rst !== 1'b1) begin failures++; $display("FAIL rst_hold_%0d: got %0h expected 1", i, filt_rst); end
    end
    cyc();
    checks++; if (filt_rst !== 1'b0) begin failures++; $display("FAIL rst_release: got %0h expected 0", filt_rst); end
    repeat (3) strobe(4'hF, 16'h1000);
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL settle_discard: got out_valid=%0h expected 0", out_valid); end
    strobe(4'hF, 16'h2000);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_cycle1: got out_valid=%0h expected 0", out_valid); end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 16'h2000) begin failures++; $display("FAIL mask_first: got v=%0h ch=%0d data=%0h expected 1/0/2000", out_valid, out_ch, out_data); end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 16'h2002) begin failures++; $display("FAIL mask_second: got v=%0h ch=%0d data=%0h expected 1/2/2002", out_valid, out_ch, out_data); end
    cyc();
    checks++; if (out_valid !== 1'b0 || overrun !== 4'h0) begin failures++; $display("FAIL mask_done: got v=%0h overrun=%0h expected 0/0", out_valid, overrun); end
  endtask

  task automatic test_cfg_err();
    apply_reset();
    do_start(16'd64, 4'h0);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || dec_rate !== 16'd256) begin failures++; $display("FAIL zero_mask: got err=%0h busy=%0h rate=%0d expected 1/0/256", cfg_err, busy, dec_rate); end
    do_start(16'd100, 4'hF);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b1 || dec_rate !== 16'd256) begin failures++; $display("FAIL bad_rate: got err=%0h busy=%0h rate=%0d expected 1/1/256", cfg_err, busy, dec_rate); end
    do_start(16'd4096, 4'hF);
    checks++; if (dec_rate !== 16'd256 || cfg_err !== 1'b1) begin failures++; $display("FAIL start_ignored: got rate=%0d err=%0h expected 256/1", dec_rate, cfg_err); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0 || filt_rst !== 1'b1) begin failures++; $display("FAIL stop_in_rst: got busy=%0h filt_rst=%0h expected 0/1", busy, filt_rst); end
    do_start(16'd64, 4'hF);
    checks++; if (cfg_err !== 1'b0 || dec_rate !== 16'd64) begin failures++; $display("FAIL good_rate: got err=%0h rate=%0d expected 0/64", cfg_err, dec_rate); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    go_run(4'hF);
    strobe(4'hF, 16'h3000);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'(i) || out_data !== 16'(16'h3000 + i)) begin failures++; $display("FAIL rr_burst1_%0d: got v=%0h ch=%0d data=%0h expected 1/%0d/%0h", i, out_valid, out_ch, out_data, i, 16'h3000 + i); end
    end
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_gap: got %0h expected 0", out_valid); end
    strobe(4'hF, 16'h4000);
    // ch0 strobes again on the cycle it is granted
    strobe(4'b0001, 16'h5000);
    checks++; if (out_ch !== 2'd0 || out_data !== 16'h4000) begin failures++; $display("FAIL rr_burst2_0: got ch=%0d data=%0h expected 0/4000", out_ch, out_data); end
    for (int i = 1; i < 4; i++) begin
      cyc();
      checks++; if (out_ch !== 2'(i) || out_data !== 16'(16'h4000 + i)) begin failures++; $display("FAIL rr_burst2_%0d: got ch=%0d data=%0h expected %0d/%0h", i, out_ch, out_data, i, 16'h4000 + i); end
    end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 16'h5000) begin failures++; $display("FAIL rr_recapture: got v=%0h ch=%0d data=%0h expected 1/0/5000", out_valid, out_ch, out_data); end
    checks++; if (overrun !== 4'h0) begin failures++; $display("FAIL rr_no_overrun: got %0h expected 0", overrun); end
  endtask

  task automatic test_overrun_stall();
    apply_reset();
    go_run(4'b0010);
    out_ready = 1'b0;
    strobe(4'b0010, 16'h6000);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 16'h6001) begin failures++; $display("FAIL stall_first: got v=%0h ch=%0d data=%0h expected 1/1/6001", out_valid, out_ch, out_data); end
    strobe(4'b0010, 16'h7000);
    checks++; if (out_data !== 16'h6001 || overrun !== 4'h0) begin failures++; $display("FAIL stall_pend: got data=%0h overrun=%0h expected 6001/0", out_data, overrun); end
    strobe(4'b0010, 16'h8000);
    checks++; if (out_data !== 16'h6001 || out_valid !== 1'b1 || overrun !== 4'b0010) begin failures++; $display("FAIL stall_overrun: got data=%0h v=%0h overrun=%0h expected 6001/1/2", out_data, out_valid, overrun); end
    out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 16'h8001) begin failures++; $display("FAIL stall_release: got v=%0h ch=%0d data=%0h expected 1/1/8001", out_valid, out_ch, out_data); end
    cyc();
    checks++; if (out_valid !== 1'b0 || overrun !== 4'b0010) begin failures++; $display("FAIL stall_sticky: got v=%0h overrun=%0h expected 0/2", out_valid, overrun); end
  endtask

  task automatic test_drain();
    apply_reset();
    go_run(4'hF);
    strobe(4'b0011, 16'h9000);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 16'h9000) begin failures++; $display("FAIL drain_first: got busy=%0h v=%0h ch=%0d data=%0h expected 1/1/0/9000", busy, out_valid, out_ch, out_data); end
    strobe(4'hF, 16'hB000);
    checks++; if (busy !== 1'b1 || out_ch !== 2'd1 || out_data !== 16'h9001) begin failures++; $display("FAIL drain_second: got busy=%0h ch=%0d data=%0h expected 1/1/9001", busy, out_ch, out_data); end
    cyc();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL drain_empty: got v=%0h busy=%0h expected 0/1", out_valid, busy); end
    cyc();
    checks++; if (busy !== 1'b0 || filt_rst !== 1'b1) begin failures++; $display("FAIL drain_idle: got busy=%0h filt_rst=%0h expected 0/1", busy, filt_rst); end
    repeat (3) cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_ignored: got v=%0h expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    go_run(4'hF);
    out_ready = 1'b0;
    strobe(4'b0001, 16'hC000);
    cyc();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hC000) begin failures++; $display("FAIL mid_pre: got v=%0h data=%0h expected 1/C000", out_valid, out_data); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || filt_rst !== 1'b1 || busy !== 1'b0 || out_data !== 16'h0) begin failures++; $display("FAIL mid_async: got v=%0h filt_rst=%0h busy=%0h data=%0h expected 0/1/0/0", out_valid, filt_rst, busy, out_data); end
    cyc();
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) cyc();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_lost: got v=%0h busy=%0h expected 0/0", out_valid, busy); end
  endtask

`ifdef SINC3_SEQ_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] t1;
    logic [31:0] t2;
    apply_reset();
    go_run(4'b0001);
    strobe(4'b0001, 16'hD000);
    cyc();
    t1 = out_ts;
    repeat (3) cyc();
    strobe(4'b0001, 16'hE000);
    cyc();
    t2 = out_ts;
    checks++; if (out_data !== 16'hE000 || (t2 - t1) !== 32'd5) begin failures++; $display("FAIL ts_delta: got data=%0h delta=%0d expected E000/5", out_data, t2 - t1); end
  endtask
`endif

  initial begin
    test_reset();
    test_settle_mask();
    test_cfg_err();
    test_round_robin();
    test_overrun_stall();
    test_drain();
    test_reset_mid();
`ifdef SINC3_SEQ_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
